// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that lets NumReq requesters share a
// single external 8x8 unsigned multiplier, one transaction at a time.
//
// Flow: IDLE (grant + latch operands) -> ISSUE (operands to multiplier)
//       -> WAIT (hold operands until mul_out_valid_i) -> RESP (hold result
//       until resp_ready_i) -> IDLE.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   req_valid_i/ready_o   per-requester handshake; ready is combinational
//                         in IDLE, at most one bit set
//   req_a_i, req_b_i      packed 8-bit operands, requester k at [8k+7:8k]
//   resp_valid_o/ready_i  result handshake
//   resp_id_o             requester index owning the result
//   resp_data_o           16-bit unsigned product
//   resp_err_o            watchdog-timeout flag
//   mul_in1_o, mul_in2_o  operands to the shared multiplier (0 in IDLE)
//   mul_out_i, mul_out_valid_i  registered multiplier result / valid
//   busy_o                high whenever the FSM is not in IDLE
//
// Build option: define MULT_ARBITER_TIMEOUT_EN to add a WAIT watchdog that
// gives up after TimeoutCycles WAIT cycles and answers with data 0, err 1.
// Without it WAIT waits forever and resp_err_o is constant 0.

module mult_arbiter #(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  output logic [NumReq-1:0]   req_ready_o,
  input  logic [8*NumReq-1:0] req_a_i,
  input  logic [8*NumReq-1:0] req_b_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [2:0]          resp_id_o,
  output logic [15:0]         resp_data_o,
  output logic                resp_err_o,
  output logic [7:0]          mul_in1_o,
  output logic [7:0]          mul_in2_o,
  input  logic [15:0]         mul_out_i,
  input  logic                mul_out_valid_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] gnt_idx;
  logic [2:0] cand;
  logic       gnt_any;
  logic       grant_ok;

  // Pad to the 8-requester maximum so a 3-bit index always fits exactly.
  logic [7:0]  req_pad;
  logic [63:0] a_pad;
  logic [63:0] b_pad;

  assign req_pad = 8'(req_valid_i);
  assign a_pad   = 64'(req_a_i);
  assign b_pad   = 64'(req_b_i);

  // Rotating priority search starting at ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = 3'((int'(ptr) + i) % NumReq);
      if (!gnt_any && req_pad[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Ready is gated by rst_i so every output reads 0 while reset is held.
  assign grant_ok = (state == IDLE) && gnt_any && !rst_i;

  for (genvar k = 0; k < NumReq; k++) begin : g_ready
    assign req_ready_o[k] = grant_ok && (gnt_idx == 3'(k));
  end

  assign busy_o = (state != IDLE);

`ifdef MULT_ARBITER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt;
`else
  assign resp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ptr          <= '0;
      resp_id_o    <= '0;
      mul_in1_o    <= '0;
      mul_in2_o    <= '0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
`ifdef MULT_ARBITER_TIMEOUT_EN
      resp_err_o   <= 1'b0;
      cnt          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            resp_id_o <= gnt_idx;
            mul_in1_o <= a_pad[{gnt_idx, 3'b000} +: 8];
            mul_in2_o <= b_pad[{gnt_idx, 3'b000} +: 8];
            ptr       <= (gnt_idx == 3'(NumReq - 1)) ? 3'd0 : gnt_idx + 3'd1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef MULT_ARBITER_TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // mul_out_valid_i is only looked at here; a valid that is stuck
          // high elsewhere cannot leak a stale product into a response.
          if (mul_out_valid_i) begin
            resp_data_o  <= mul_out_i;
            resp_valid_o <= 1'b1;
`ifdef MULT_ARBITER_TIMEOUT_EN
            resp_err_o   <= 1'b0;
`endif
            state        <= RESP;
          end
`ifdef MULT_ARBITER_TIMEOUT_EN
          else if (cnt == CntW'(TimeoutCycles - 1)) begin
            resp_data_o  <= '0;
            resp_err_o   <= 1'b1;
            resp_valid_o <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            mul_in1_o    <= '0;
            mul_in2_o    <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TimeoutCycles, default 8, WAIT-state watchdog limit (used only with MULT_ARBITER_TIMEOUT_EN).
REQ-003 SHALL have port clk_i  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid_i  input  NumReq  per-requester request valid.
REQ-006 SHALL have port req_ready_o  output  NumReq  per-requester accept, at most one bit set.
REQ-007 SHALL have port req_a_i  input  8*NumReq  packed operand A, requester k at bits [8k+7:8k].
REQ-008 SHALL have port req_b_i  input  8*NumReq  packed operand B, same packing.
REQ-009 SHALL have port resp_valid_o  input-facing output  1  result valid.
REQ-010 SHALL have port resp_ready_i  input  1  result accept.
REQ-011 SHALL have port resp_id_o  output  3  index of requester owning the result.
REQ-012 SHALL have port resp_data_o  output  16  product.
REQ-013 SHALL have port resp_err_o  output  1  watchdog-timeout flag.
REQ-014 SHALL have ports mul_in1_o, mul_in2_o  output  8 each  operands to the shared 8x8 multiplier.
REQ-015 SHALL have ports mul_out_i  input  16, mul_out_valid_i  input  1  registered multiplier result and valid.
REQ-016 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: SHALL grant the first set req_valid_i bit at or after round-robin pointer ptr (wrapping NumReq-1 -> 0), asserting req_ready_o[g] combinationally in the same cycle.
REQ-019 On grant SHALL latch req_a_i/req_b_i slice g and g, set ptr = (g+1) mod NumReq, go to ISSUE; no grant -> stay IDLE, req_ready_o = 0.
REQ-020 ISSUE: SHALL drive latched operands on mul_in1_o/mul_in2_o for one cycle, then go to WAIT.
REQ-021 WAIT: SHALL hold operands stable; on first WAIT cycle with mul_out_valid_i=1 SHALL capture mul_out_i into resp_data_o, resp_err_o=0, go to RESP.
REQ-022 mul_out_valid_i levels outside WAIT SHALL be ignored (multiplier valid may stay high continuously).
REQ-023 RESP: SHALL assert resp_valid_o with resp_id_o=g; data/id/err stable until resp_ready_i=1; on handshake go to IDLE.
REQ-024 No grant SHALL occur in the RESP-to-IDLE handshake cycle; min interval between grants is 4 cycles.
REQ-025 Latency: grant at cycle T -> resp_valid_o high at T+3 with a 1-cycle multiplier.
REQ-026 req_ready_o SHALL be 0 in ISSUE, WAIT, RESP; requesters dropping req_valid_i while not granted lose nothing.
REQ-027 mul_in1_o/mul_in2_o SHALL be 0 in IDLE.
REQ-028 Product SHALL be full 16-bit unsigned, no truncation (255*255 = 65025).

Reset
REQ-029 rst_i high SHALL asynchronously force state IDLE, ptr=0, all outputs 0, latched operands/result 0.
REQ-030 Reset asserted mid-operation SHALL abandon the transaction; no response SHALL be produced for it after release.
REQ-031 First grant after reset release SHALL favour requester 0.

Configuration
REQ-032 With MULT_ARBITER_TIMEOUT_EN defined: WAIT SHALL count cycles; after TimeoutCycles WAIT cycles without mul_out_valid_i, SHALL enter RESP with resp_data_o=0, resp_err_o=1.
REQ-033 Without MULT_ARBITER_TIMEOUT_EN: WAIT SHALL wait indefinitely, no counter SHALL be built, resp_err_o tied 0.

Verification
REQ-034 Req0 A=2 B=7, resp_ready_i=1 -> resp_valid_o at T+3, resp_data_o=14, resp_id_o=0, resp_err_o=0.
REQ-035 Req0,1,2 all valid (211*98, 123*77, 255*255) -> responses in id order 0,1,2 with 20678, 9471, 65025; each grant >=4 cycles apart.
REQ-036 After ptr=2, req1 and req3 valid -> req3 granted first, then req1 (wrap-around).
REQ-037 resp_ready_i held 0 for 5 cycles in RESP -> resp_valid_o/data/id stable, req_ready_o=0, busy_o=1; released -> IDLE next cycle.
REQ-038 rst_i pulsed in WAIT -> all outputs 0 immediately, no response after release, next grant to req0.
REQ-039 With macro, mul_out_valid_i held 0 -> after 8 WAIT cycles resp_valid_o=1, resp_err_o=1, resp_data_o=0.
